// File: rtl/cla16_seq_pkg.sv
// ============================================================================
// Module   : cla16_seq_pkg
// Brief    : Shared types and sizing for the sequential 16-bit lookahead adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cla16_seq_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla16_seq_pkg

`default_nettype wire

// File: rtl/cla16_seq_ctrl_cla4_slice.sv
// ============================================================================
// Module   : cla4_slice
// Brief    : Purely combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla4_slice
  import cla16_seq_pkg::*;
(
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             Ci,
  output logic [SLICE-1:0] S,
  output logic             Co,
  output logic             PG,
  output logic             GG
);

  logic [SLICE-1:0] p_w;
  logic [SLICE-1:0] g_w;
  logic [SLICE:0]   c_w;

  assign p_w = A ^ B;
  assign g_w = A & B;

  // Every carry is a flat sum of products of Ci and the bit generates.
  assign c_w[0] = Ci;
  assign c_w[1] = g_w[0] | (p_w[0] & Ci);
  assign c_w[2] = g_w[1] | (p_w[1] & g_w[0]) | (p_w[1] & p_w[0] & Ci);
  assign c_w[3] = g_w[2] | (p_w[2] & g_w[1]) | (p_w[2] & p_w[1] & g_w[0])
                | (p_w[2] & p_w[1] & p_w[0] & Ci);

  assign PG = &p_w;
  assign GG = g_w[3] | (p_w[3] & g_w[2]) | (p_w[3] & p_w[2] & g_w[1])
            | (p_w[3] & p_w[2] & p_w[1] & g_w[0]);
  assign c_w[4] = GG | (PG & Ci);
  assign Co     = c_w[4];

  for (genvar i = 0; i < SLICE; i++) begin : g_sum
    assign S[i] = p_w[i] ^ c_w[i];
  end

endmodule : cla4_slice

`default_nettype wire

// File: rtl/cla16_seq_ctrl.sv
// ============================================================================
// Module   : cla16_seq_ctrl
// Brief    : 16-bit add over four cycles through one 4-bit lookahead slice.
//            Optional subtract mode (op port) under CLA16_SEQ_SUBTRACT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla16_seq_ctrl
  import cla16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA16_SEQ_SUBTRACT_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg_all
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             pg_all_q, pg_all_d;
`ifdef CLA16_SEQ_SUBTRACT_EN
  logic             op_q, op_d;
`endif

  logic [WIDTH-1:0] b_eff_w;
  logic             cin_eff_w;
  logic [SLICE-1:0] s_w;
  logic             co_w;
  logic             pg_w;
  logic             gg_w;

`ifdef CLA16_SEQ_SUBTRACT_EN
  // Subtract is a + ~b + 1; the carry-in seeds the +1 so cin is ignored.
  assign b_eff_w   = op_q ? ~b_q : b_q;
  assign cin_eff_w = op ? 1'b1 : cin;
`else
  assign b_eff_w   = b_q;
  assign cin_eff_w = cin;
`endif

  cla4_slice u_slice (
    .A  (a_q[SLICE*idx_q +: SLICE]),
    .B  (b_eff_w[SLICE*idx_q +: SLICE]),
    .Ci (carry_q),
    .S  (s_w),
    .Co (co_w),
    .PG (pg_w),
    .GG (gg_w)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    pg_all_d = pg_all_q;
`ifdef CLA16_SEQ_SUBTRACT_EN
    op_d     = op_q;
`endif

    case (state_q)
      IDLE: begin
        if (!abort && in_valid) begin
          a_d      = a;
          b_d      = b;
          carry_d  = cin_eff_w;
          idx_d    = 2'd0;
          pg_all_d = 1'b1;
`ifdef CLA16_SEQ_SUBTRACT_EN
          op_d     = op;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sum_d[SLICE*idx_q +: SLICE] = s_w;
          carry_d  = co_w;
          pg_all_d = pg_all_q & pg_w;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'(NSLICE - 1)) begin
            // Top nibble: s_w[3] is the final sum[15].
            cout_d  = co_w;
            ovf_d   = (a_q[WIDTH-1] == b_eff_w[WIDTH-1]) && (s_w[SLICE-1] != a_q[WIDTH-1]);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= 2'd0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pg_all_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      pg_all_q <= pg_all_d;
    end
  end

`ifdef CLA16_SEQ_SUBTRACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
    end else begin
      op_q <= op_d;
    end
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign pg_all    = pg_all_q;

endmodule : cla16_seq_ctrl

`default_nettype wire

// File: tb/tb_cla16_seq_ctrl.sv
// ============================================================================
// Module   : tb_cla16_seq_ctrl
// Brief    : Directed self-checking bench for cla16_seq_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef CLA16_SEQ_SUBTRACT_EN
  logic        op = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        pg_all;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla16_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA16_SEQ_SUBTRACT_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .pg_all    (pg_all)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and confirm out_valid rises exactly 4 edges later.
  task automatic apply(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                       input logic iop);
    check("in_ready_before_accept", in_ready, 1);
    a = ia; b = ib; cin = icin;
`ifdef CLA16_SEQ_SUBTRACT_EN
    op = iop;
`else
    if (iop) $display("note: op ignored in add-only build");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("in_ready_after_accept", in_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("out_valid_edge%0d", k), out_valid, (k == 4) ? 1 : 0);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_pg_all"}, pg_all, 0);
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Basic add, no carries between nibbles.
    apply(16'h1234, 16'h4321, 1'b0, 1'b0);
    check("v1_sum", sum, 32'h5555);
    check("v1_cout", cout, 0);
    check("v1_ovf", ovf, 0);
    handshake();

    // Carry ripples through every nibble; all nibbles fully propagate.
    apply(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check("v2_sum", sum, 32'h0000);
    check("v2_cout", cout, 1);
    check("v2_ovf", ovf, 0);
    check("v2_pg_all", pg_all, 1);
    handshake();

    // Signed overflow positive + positive -> negative.
    apply(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("v3_sum", sum, 32'h8000);
    check("v3_cout", cout, 0);
    check("v3_ovf", ovf, 1);
    check("v3_pg_all", pg_all, 0);
    handshake();

    // Backpressure in DONE: results held, no new accept.
    apply(16'h00F0, 16'h0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 32'h0100);
      check("bp_in_ready", in_ready, 0);
    end
    handshake();

    // Abort wins over in_valid in IDLE.
    a = 16'h0F0F; b = 16'h0F0F; in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_in_ready", in_ready, 1);

    // Abort in the second RUN cycle.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_in_ready", in_ready, 1);
    check("abort_run_out_valid", out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
    apply(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("v5_sum", sum, 32'h0002);
    check("v5_cout", cout, 0);
    handshake();

`ifdef CLA16_SEQ_SUBTRACT_EN
    apply(16'h0005, 16'h0007, 1'b1, 1'b1);
    check("sub_sum", sum, 32'hFFFE);
    check("sub_cout", cout, 0);
    check("sub_ovf", ovf, 0);
    handshake();
    op = 1'b0;
`endif

    // Reset pulse mid-RUN discards the operation.
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    check_reset_vals("midrun_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_reset_no_valid", out_valid, 0);
    end
    check("post_reset_sum", sum, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_cla16_seq_ctrl

`default_nettype wire
